hazard_scoreboard: RTL and testbench

//  Producer-side complement of operand forwarding in the in-order pipeline. Tracks rd of in-flight

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: register address width,
// register count, and a one-hot decode helper used by the pending mask.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input reg_addr_t a
  );
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-bit scoreboard for long-latency writers; stalls ID on RAW/WAW
// hits and on a full tracker.
// Ports:
//   in  clk, rst_n, id_* (ID operand info), ex_hold, flush, cmp_valid/cmp_rd
//   out stall_id, pending_vec, outstanding, stall_cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_W     = 32,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  reg_addr_t              id_rs1,
  input  reg_addr_t              id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  reg_addr_t              id_rd,
  input  logic                   id_reg_wr,
  input  logic                   id_long_lat,
  input  logic                   ex_hold,
  input  logic                   flush,
  input  logic                   cmp_valid,
  input  reg_addr_t              cmp_rd,
  output logic                   stall_id,
  output logic [NUM_REGS-1:0]    pending_vec,
  output logic [CNT_W-1:0]       outstanding,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] cmp_mask;
  logic [NUM_REGS-1:0] fl_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic [CNT_W-1:0]    cnt_q;
  reg_addr_t           ex_rd_q;
  logic                ex_long_q;

  logic haz_rs1;
  logic haz_rs2;
  logic haz_waw;
  logic haz_full;
  logic full;
  logic issue;
  logic track;
  logic dec_cmp;
  logic dec_fl;

  // A result completing this cycle is forwardable, so its bit
  // no longer blocks consumers.
  always_comb begin
    cmp_mask = '0;
    fl_mask  = '0;
    set_mask = '0;
    if (cmp_valid)
      cmp_mask = reg_onehot(cmp_rd);
    if (dec_fl)
      fl_mask = reg_onehot(ex_rd_q);
    if (track)
      set_mask = reg_onehot(id_rd);
  end

  assign pend_eff = pending_q & ~cmp_mask;
  assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));

  assign haz_rs1 = id_use_rs1 && (id_rs1 != '0)
                && pend_eff[id_rs1];
  assign haz_rs2 = id_use_rs2 && (id_rs2 != '0)
                && pend_eff[id_rs2];
  assign haz_waw = id_reg_wr && (id_rd != '0)
                && pend_eff[id_rd];
  assign haz_full = id_long_lat && id_reg_wr
                 && (id_rd != '0) && full
                 && !cmp_valid;

  assign stall_id = id_valid && !flush
                 && (haz_rs1 || haz_rs2
                  || haz_waw || haz_full);

  assign issue = id_valid && !stall_id
              && !ex_hold && !flush;
  assign track = issue && id_long_lat
              && id_reg_wr && (id_rd != '0);

  // A stray completion on an idle register must not decrement.
  assign dec_cmp = cmp_valid && pending_q[cmp_rd];
  assign dec_fl  = flush && ex_long_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      ex_rd_q   <= '0;
      ex_long_q <= 1'b0;
    end else begin
      // set is applied last so it wins over a same-index clear
      pending_q <= (pending_q & ~cmp_mask & ~fl_mask)
                 | set_mask;
      cnt_q <= cnt_q + CNT_W'(track)
             - CNT_W'(dec_cmp) - CNT_W'(dec_fl);
      if (issue) begin
        ex_rd_q   <= id_rd;
        ex_long_q <= track;
      end else if (!ex_hold || flush) begin
        ex_long_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall_id && (stall_cycles != '1))
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

  assign pending_vec = pending_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard with a set-based reference
// model, plus directed scenarios pinned to literal expectations.
module tb_hazard_scoreboard;

  localparam int MAXO = 2;
  localparam int SCW  = 6;
  localparam int OW   = $clog2(MAXO + 1);

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      id_rd;
  logic            id_reg_wr;
  logic            id_long_lat;
  logic            ex_hold;
  logic            flush;
  logic            cmp_valid;
  logic [4:0]      cmp_rd;
  logic            stall_id;
  logic [31:0]     pending_vec;
  logic [OW-1:0]   outstanding;
  logic [SCW-1:0]  stall_cycles;

  hazard_scoreboard #(
    .MAX_OUTSTANDING(MAXO),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rd(id_rd),
    .id_reg_wr(id_reg_wr),
    .id_long_lat(id_long_lat),
    .ex_hold(ex_hold),
    .flush(flush),
    .cmp_valid(cmp_valid),
    .cmp_rd(cmp_rd),
    .stall_id(stall_id),
    .pending_vec(pending_vec),
    .outstanding(outstanding),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: set of registers awaiting a long-latency result, plus
  // the identity of the instruction sitting in EX.
  bit   busy [32];
  bit   m_ex_long;
  int   m_ex_rd;
  int   m_stalls;

  function automatic int n_busy();
    int n = 0;
    for (int r = 0; r < 32; r++)
      if (busy[r]) n++;
    return n;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++)
      v[r] = busy[r];
    return v;
  endfunction

  function automatic bit blocks(input int r);
    if (r == 0) return 1'b0;
    if (!busy[r]) return 1'b0;
    if (cmp_valid && int'(cmp_rd) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_stall();
    bit h = 0;
    if (!id_valid || flush) return 1'b0;
    if (id_use_rs1 && blocks(int'(id_rs1))) h = 1;
    if (id_use_rs2 && blocks(int'(id_rs2))) h = 1;
    if (id_reg_wr && blocks(int'(id_rd))) h = 1;
    if (id_long_lat && id_reg_wr && id_rd != 0
        && n_busy() == MAXO && !cmp_valid) h = 1;
    return h;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) busy[r] = 0;
    m_ex_long = 0;
    m_ex_rd   = 0;
    m_stalls  = 0;
  endtask

  task automatic model_clock(input bit st);
    bit iss;
    bit trk;
    iss = id_valid && !st && !ex_hold && !flush;
    trk = iss && id_long_lat && id_reg_wr
       && id_rd != 0;
    if (cmp_valid) busy[cmp_rd] = 0;
    if (flush && m_ex_long) busy[m_ex_rd] = 0;
    if (trk) busy[id_rd] = 1;
    if (iss) begin
      m_ex_rd   = int'(id_rd);
      m_ex_long = trk;
    end else if (!ex_hold || flush) begin
      m_ex_long = 0;
    end
    if (st && m_stalls < (1 << SCW) - 1)
      m_stalls++;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid    = 0;
    id_rs1      = 0;
    id_rs2      = 0;
    id_use_rs1  = 0;
    id_use_rs2  = 0;
    id_rd       = 0;
    id_reg_wr   = 0;
    id_long_lat = 0;
    ex_hold     = 0;
    flush       = 0;
    cmp_valid   = 0;
    cmp_rd      = 0;
  endtask

  task automatic id_long(input int rd);
    id_valid    = 1;
    id_reg_wr   = 1;
    id_long_lat = 1;
    id_rd       = 5'(rd);
  endtask

  // Called at posedge+1 with inputs driven; compares at negedge,
  // advances the model, returns at the next posedge+1.
  task automatic step();
    bit st;
    st = model_stall();
    @(negedge clk);
    chk("stall_id", 64'(stall_id), 64'(st));
    chk("pending_vec", 64'(pending_vec), 64'(busy_vec()));
    chk("outstanding", 64'(outstanding), 64'(n_busy()));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    model_clock(st);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    int r;
    idle();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_rs1      = 5'($urandom_range(0, 7));
    id_rs2      = 5'($urandom_range(0, 7));
    id_use_rs1  = 1'($urandom_range(0, 1));
    id_use_rs2  = 1'($urandom_range(0, 1));
    id_rd       = 5'($urandom_range(0, 7));
    id_reg_wr   = ($urandom_range(0, 3) != 0);
    id_long_lat = ($urandom_range(0, 2) == 0);
    ex_hold     = ($urandom_range(0, 4) == 0);
    flush       = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 2) == 0) begin
      r = $urandom_range(0, 9);
      // a writer still in EX cannot already be completing
      if (!(m_ex_long && m_ex_rd == r)) begin
        if (busy[r] || n_busy() < MAXO) begin
          cmp_valid = 1;
          cmp_rd    = 5'(r);
        end
      end
    end
    step();
  endtask

  initial begin
    rst_n = 0;
    do_reset();

    // reset state
    #1;
    chk("rst_pending", 64'(pending_vec), 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'h0);

    // load rd=5 then a consumer of x5
    idle(); id_long(5); step();
    chk("ld_pending", 64'(pending_vec), 64'h20);
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", 64'(stall_id), 64'h1);
      step();
    end
    cmp_valid = 1; cmp_rd = 5;
    #1 chk("raw_release", 64'(stall_id), 64'h0);
    step();
    chk("raw_cleared", 64'(pending_vec), 64'h0);
    chk("raw_stall_cnt", 64'(stall_cycles), 64'h3);

    // flush kills a long writer still in EX
    idle(); id_long(5); step();
    idle(); flush = 1; id_valid = 1;
    id_use_rs1 = 1; id_rs1 = 5;
    #1 chk("flush_no_stall", 64'(stall_id), 64'h0);
    step();
    idle();
    #1;
    chk("flush_pending", 64'(pending_vec), 64'h0);
    chk("flush_outstanding", 64'(outstanding), 64'h0);

    // tracker full, completion frees a slot in the same cycle
    idle(); id_long(1); step();
    idle(); id_long(2); step();
    idle(); id_long(3);
    #1 chk("full_stall", 64'(stall_id), 64'h1);
    step();
    cmp_valid = 1; cmp_rd = 1;
    #1 chk("full_release", 64'(stall_id), 64'h0);
    step();
    chk("full_pending", 64'(pending_vec), 64'h0C);
    chk("full_outstanding", 64'(outstanding), 64'h2);
    idle(); cmp_valid = 1; cmp_rd = 2; step();
    idle(); cmp_valid = 1; cmp_rd = 3; step();

    // WAW resolved by same-cycle completion on the same rd
    idle(); id_long(7); step();
    idle(); step();
    idle(); id_long(7); cmp_valid = 1; cmp_rd = 7;
    #1 chk("waw_release", 64'(stall_id), 64'h0);
    step();
    chk("waw_pending", 64'(pending_vec), 64'h80);
    chk("waw_outstanding", 64'(outstanding), 64'h1);
    idle(); cmp_valid = 1; cmp_rd = 7; step();

    // x0 never tracked, never stalls; stray completion ignored
    idle(); id_long(0); step();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 0;
    #1 chk("x0_no_stall", 64'(stall_id), 64'h0);
    step();
    idle(); cmp_valid = 1; cmp_rd = 9; step();
    chk("x0_pending", 64'(pending_vec), 64'h0);
    chk("stray_outstanding", 64'(outstanding), 64'h0);

    // reset in the middle of activity
    idle(); id_long(5); step();
    idle(); step();
    chk("pre_rst_pending", 64'(pending_vec), 64'h20);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pending", 64'(pending_vec), 64'h0);
    chk("async_rst_outstanding", 64'(outstanding), 64'h0);
    chk("async_rst_stalls", 64'(stall_cycles), 64'h0);
    do_reset();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    #1 chk("post_rst_stall", 64'(stall_id), 64'h0);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      rand_cycle();
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
